// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: BCD keypad time entry, 1 Hz countdown while cooking,
// door/stop pause handling and a three-second completion beep.
module cook_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit,
   input  logic       digit_valid,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       door_closed,
   input  logic       tick_1hz,
   output logic [3:0] minutes,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       mag_on,
   output logic       beep,
   output logic [2:0] state,
   output logic       entry_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t     cur, nxt;
   logic [3:0] nxt_m, nxt_t, nxt_o;
   logic [3:0] dec_m, dec_t, dec_o;
   logic [1:0] beep_cnt, nxt_cnt;
   logic       nxt_err, nxt_mag, nxt_beep;
   logic       dig_ok, time_zero, start_ok, dec_zero;

   assign state     = cur;
   assign dig_ok    = digit_valid && (digit <= 4'd9);
   assign time_zero = (minutes == 4'd0) && (secs_tens == 4'd0) && (secs_ones == 4'd0);
   assign start_ok  = door_closed && !time_zero && (secs_tens <= 4'd5);
   assign dec_zero  = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_o == 4'd0);

   // One-second BCD decrement with borrow through tens into minutes
   always_comb begin
      dec_m = minutes;
      dec_t = secs_tens;
      dec_o = secs_ones - 4'd1;
      if (secs_ones == 4'd0) begin
         dec_o = 4'd9;
         if (secs_tens != 4'd0) begin
            dec_t = secs_tens - 4'd1;
         end else begin
            dec_t = 4'd5;
            dec_m = minutes - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= IDLE;
         minutes   <= 4'd0;
         secs_tens <= 4'd0;
         secs_ones <= 4'd0;
         beep_cnt  <= 2'd0;
         mag_on    <= 1'b0;
         beep      <= 1'b0;
         entry_err <= 1'b0;
      end else begin
         cur       <= nxt;
         minutes   <= nxt_m;
         secs_tens <= nxt_t;
         secs_ones <= nxt_o;
         beep_cnt  <= nxt_cnt;
         mag_on    <= nxt_mag;
         beep      <= nxt_beep;
         entry_err <= nxt_err;
      end
   end

   always_comb begin
      nxt     = cur;
      nxt_m   = minutes;
      nxt_t   = secs_tens;
      nxt_o   = secs_ones;
      nxt_cnt = beep_cnt;
      nxt_err = 1'b0;
      case (cur)
         IDLE, ENTRY: begin
            if (cur == ENTRY && start) begin
               if (start_ok) nxt = COOK;
               else          nxt_err = 1'b1;
            end else if (dig_ok) begin
               nxt   = ENTRY;
               nxt_m = secs_tens;
               nxt_t = secs_ones;
               nxt_o = digit;
            end
         end
         COOK: begin
            // Pausing wins over a coincident tick so no second is lost
            if (!door_closed || stop) begin
               nxt = PAUSE;
            end else if (tick_1hz) begin
               nxt_m = dec_m;
               nxt_t = dec_t;
               nxt_o = dec_o;
               if (dec_zero) begin
                  nxt     = DONE;
                  nxt_cnt = 2'd0;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               nxt   = IDLE;
               nxt_m = 4'd0;
               nxt_t = 4'd0;
               nxt_o = 4'd0;
            end else if (start && door_closed) begin
               nxt = COOK;
            end
         end
         DONE: begin
            if (tick_1hz) begin
               if (beep_cnt == 2'd2) begin
                  nxt     = IDLE;
                  nxt_cnt = 2'd0;
               end else begin
                  nxt_cnt = beep_cnt + 2'd1;
               end
            end else if (dig_ok) begin
               nxt     = ENTRY;
               nxt_m   = 4'd0;
               nxt_t   = 4'd0;
               nxt_o   = digit;
               nxt_cnt = 2'd0;
            end
         end
         default: nxt = IDLE;
      endcase
      if (clear) begin
         nxt     = IDLE;
         nxt_m   = 4'd0;
         nxt_t   = 4'd0;
         nxt_o   = 4'd0;
         nxt_cnt = 2'd0;
         nxt_err = 1'b0;
      end
   end

   always_comb begin
      nxt_mag  = (nxt == COOK);
      nxt_beep = (nxt == DONE);
   end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: digit  in  4  BCD keypad digit, sampled only when digit_valid=1.
REQ-004 SHALL have ports: digit_valid  in  1  one-cycle strobe, new keypad digit.
REQ-005 SHALL have ports: start  in  1  one-cycle pulse, start/resume request.
REQ-006 SHALL have ports: stop  in  1  one-cycle pulse, pause/cancel request.
REQ-007 SHALL have ports: clear  in  1  one-cycle pulse, abort and zero time.
REQ-008 SHALL have ports: door_closed  in  1  level, 1 = door closed.
REQ-009 SHALL have ports: tick_1hz  in  1  one-cycle pulse, once per second.
REQ-010 SHALL have ports: minutes, secs_tens, secs_ones  out  4 each  registered BCD remaining/entered time.
REQ-011 SHALL have ports: mag_on  out  1  registered, 1 only in COOK.
REQ-012 SHALL have ports: beep  out  1  registered, 1 only in DONE.
REQ-013 SHALL have ports: state  out  3  encoding IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.
REQ-014 SHALL have ports: entry_err  out  1  registered one-cycle pulse, start rejected.

Function
REQ-015 SHALL implement FSM states IDLE, ENTRY, COOK, PAUSE, DONE; all outputs registered, effect visible the cycle after the causing input.
REQ-016 SHALL apply per-cycle event priority: clear > door open (door_closed=0) > stop > start > tick_1hz > digit_valid.
REQ-017 SHALL, on clear in any state, go to IDLE and zero minutes/secs_tens/secs_ones.
REQ-018 SHALL, on digit_valid in IDLE/ENTRY with digit<=9, shift left: minutes<=secs_tens, secs_tens<=secs_ones, secs_ones<=digit; old minutes discarded; state->ENTRY.
REQ-019 SHALL ignore digit_valid with digit>9 in every state.
REQ-020 SHALL ignore digit_valid in COOK and PAUSE.
REQ-021 SHALL, on valid digit in DONE, load time 0:0<digit>, deassert beep, go to ENTRY.
REQ-022 SHALL, on start in ENTRY, go to COOK only if door_closed=1, time non-zero, secs_tens<=5; otherwise stay in ENTRY and pulse entry_err for one cycle.
REQ-023 SHALL ignore start in IDLE, COOK, DONE.
REQ-024 SHALL, on tick_1hz in COOK, decrement time in BCD: ones>0 -> ones-1; else ones=9 and tens>0 -> tens-1; else tens=5, minutes-1.
REQ-025 SHALL, when a decrement yields 0:00, go to DONE on that same edge, so mag_on falls with the display reaching 0:00.
REQ-026 SHALL, on door open or stop in COOK, go to PAUSE without decrementing, even if tick_1hz coincides.
REQ-027 SHALL, on start in PAUSE with door_closed=1, return to COOK, time unchanged; start with door open ignored.
REQ-028 SHALL, on stop in PAUSE, go to IDLE and zero time.
REQ-029 SHALL hold beep=1 in DONE for exactly 3 tick_1hz pulses, then go to IDLE with time 0:00.
REQ-030 SHALL ignore tick_1hz in IDLE, ENTRY, PAUSE.
REQ-031 SHALL never assert mag_on while door_closed=0 for more than the one cycle of register latency.

Reset
REQ-032 SHALL, while rst=1, force state=IDLE, time 0:00, mag_on=0, beep=0, entry_err=0, beep tick count=0, independent of clk.
REQ-033 SHALL, on rst mid-COOK, drop mag_on immediately (asynchronous) and discard remaining time.

Verification
REQ-034 SHALL cover: digits 1,3,0 then start (door closed) -> time 1:30, mag_on=1 next cycle; 1 tick -> 1:29; 31 ticks total -> 0:59.
REQ-035 SHALL cover: time 0:02 in COOK, 2 ticks -> 0:00 with state=DONE, mag_on=0, beep=1; 3 more ticks -> IDLE, beep=0.
REQ-036 SHALL cover: COOK at 0:45, door_closed=0 same cycle as tick -> PAUSE, time stays 0:45; door closes, start -> COOK at 0:45.
REQ-037 SHALL cover: entry 0:75 then start -> state ENTRY, entry_err pulses one cycle; entry 0:00 then start -> same.
REQ-038 SHALL cover: clear, stop and start asserted together in COOK -> IDLE, time 0:00; rst pulse mid-COOK -> mag_on=0 without a clk edge.
REQ-039 SHALL cover: digits 9,9,9,1 -> time 9:91 (oldest discarded); digit 0xA ignored; stop in PAUSE -> IDLE at 0:00.
